video_mem_arbiter: RTL
======================

# video_mem_arbiter

Two-requester arbiter that shares the single video-memory Wishbone port between the display fetch path (requester 0, feeding the VGA timing/pixel path) and the frame writer (requester 1, e.g. pattern generator or CPU bridge). It uses registered round-robin grant with a bounded burst length, so neither side can starve the other. It sits between the two Wishbone classic masters and the memory controller, in the pixel clock domain.

## Interface
Parameters:
- AW, 32, address width of all Wishbone ports
- DW, 32, data width; byte selects are DW/8 bits
- MAX_BEATS, 16, acknowledged beats an owner may complete while the other requester waits; legal range ≥1

Ports:
- pixel_clk  in  1  single clock; all logic on rising edge
- pixel_rst  in  1  reset, synchronous, active-high
- r0_cyc, r0_stb, r0_we  in  1 each  display requester bus-cycle, strobe, write enable
- r0_adr  in  AW  display address
- r0_dat_w  in  DW  display write data
- r0_sel  in  DW/8  display byte selects
- r0_ack  out  1  display acknowledge
- r0_dat_r  out  DW  read data, driven from m_dat_r
- r1_cyc, r1_stb, r1_we, r1_adr, r1_dat_w, r1_sel, r1_ack, r1_dat_r  same directions, widths and meaning for the writer
- m_cyc, m_stb, m_we  out  1 each  memory-side cycle, strobe, write enable
- m_adr  out  AW;  m_dat_w  out  DW;  m_sel  out  DW/8
- m_ack  in  1;  m_dat_r  in  DW  memory-side acknowledge and read data
- gnt  out  2  one-hot current owner (bit i = ri); 2'b00 when idle

## Operation
- FSM states: IDLE, GRANT0, GRANT1. State, last-owner pointer `last` and beat counter `beats` are registered.
- IDLE:
  - Only r0_cyc high → GRANT0. Only r1_cyc high → GRANT1.
  - Both high → grant the requester ≠ `last`.
  - On entry to a GRANTi: `beats` ← 0, `last` ← i.
- GRANTi:
  - m_cyc/m_stb/m_we/m_adr/m_dat_w/m_sel combinationally mirror ri_*.
  - ri_ack = m_ack. The other requester's ack = 0.
  - Each cycle with m_ack high increments `beats`. The counter saturates at MAX_BEATS and is $clog2(MAX_BEATS+1) bits wide.
- Leaving GRANTi, GRANTi → IDLE when either:
  - ri_cyc is low, or
  - the increment makes `beats` reach MAX_BEATS while the other requester's cyc is high.
  The preempted master sees no further ack and keeps stb asserted; this is a legal Wishbone stall. It re-wins later through round-robin.
- While idle, all m_* control outputs are 0. m_adr, m_dat_w and m_sel are 0.
- r0_dat_r and r1_dat_r are always m_dat_r. A requester only samples them on its own ack.
- No timeout: if the slave never acks, the grant is held indefinitely.

## Timing
- Reset: state IDLE, `last` = 1 (so r0 wins the first tie), `beats` = 0, gnt = 0, m_cyc = m_stb = m_we = 0, r0_ack = r1_ack = 0.
- Grant latency: ri_cyc rising in cycle N while IDLE → m_cyc high in cycle N+1.
- Handover: at least one cycle with m_cyc = 0 between two owners. Back-to-back bursts to different owners have a 1-cycle bubble.
- Release on cyc drop: ri_cyc low in cycle N → m_cyc low from cycle N+1. In cycle N, m_cyc already follows ri_cyc = 0 combinationally.
- Preemption: the edge that registers the MAX_BEATS-th ack moves the FSM to IDLE. The next cycle has m_cyc = 0 and the other requester is granted one cycle later.
- Acks are purely combinational, with zero added latency.
- Simultaneous events:
  - Owner drops cyc on the same edge its count hits MAX_BEATS → treated as a normal release.
  - New request from the non-owner during a grant only takes effect via IDLE.
- pixel_rst mid-transfer: the next cycle is in reset state, with m_cyc = 0 and no ack forwarded. The in-flight beat is abandoned; the masters must restart.

## Structure
- Package video_mem_pkg:
  - arb_state_t enum {IDLE, GRANT0, GRANT1}
  - default AW/DW constants shared with the display fetch and writer blocks
- Single module, no sub-module. The round-robin pick is a two-line function in the package.

## Test plan
- Reset: hold pixel_rst 3 cycles with both cyc high → gnt = 00, m_cyc = 0, both acks 0. After release, gnt = 01 one cycle later.
- Single r0 read of 4 beats, slave acks every cycle with m_dat_r = 0x100..0x103 → r0_ack 4 pulses, r0_dat_r matches, r1_ack never high, m_cyc low the cycle r0_cyc drops.
- Tie after reset: both request 2-beat writes → r0 served first, one idle m_cyc cycle, then r1. r1's m_adr/m_dat_w appear exactly while gnt = 10.
- Preemption, MAX_BEATS = 16: r0 streams 40 beats, r1 requests at beat 3 → r0 gets 16 acks, 1 idle cycle, r1 granted. After r1 drops cyc, r0 resumes at beat 17 with address unchanged.
- Slave stall: m_ack low for 50 cycles in GRANT1 with r0 waiting → grant held, no ack to r0, beats = 0.
- Reset mid-beat during GRANT1 with r1_stb high → next cycle gnt = 00, m_cyc = 0. With both requesting afterward, r0 wins.

Source files
------------

// File: rtl/video_mem_pkg.sv
// -----------------------------------------------------------------------------
// video_mem_pkg
//   Shared definitions for the video-memory path: the arbiter state encoding,
//   the default Wishbone address/data widths used by the display fetch path,
//   the frame writer and the arbiter, and the round-robin pick helper.
// -----------------------------------------------------------------------------
package video_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   localparam int VMEM_AW = 32;
   localparam int VMEM_DW = 32;

   // Index of the requester to grant from IDLE. On a tie the requester that
   // did not own the bus last wins; otherwise whoever is asking wins.
   function automatic logic rr_pick(input logic req0, input logic req1,
                                    input logic last);
      return (req0 && req1) ? ~last : req1;
   endfunction

endpackage

// File: rtl/video_mem_arbiter.sv
// -----------------------------------------------------------------------------
// video_mem_arbiter
//   Shares the single video-memory Wishbone classic port between the display
//   fetch path (r0) and the frame writer (r1). Registered round-robin grant
//   with a bounded burst: an owner may complete MAX_BEATS acknowledged beats
//   while the other requester waits, then it is sent back through IDLE.
//
// Ports
//   pixel_clk, pixel_rst      clock, synchronous active-high reset
//   r0_* / r1_*               Wishbone classic slave ports for the requesters
//                             (cyc, stb, we, adr, dat_w, sel in; ack, dat_r out)
//   m_*                       Wishbone classic master port to the memory
//                             controller (cyc, stb, we, adr, dat_w, sel out;
//                             ack, dat_r in)
//   gnt                       one-hot current owner, 2'b00 when idle
// -----------------------------------------------------------------------------
module video_mem_arbiter
   import video_mem_pkg::*;
#(
   parameter int AW        = VMEM_AW,
   parameter int DW        = VMEM_DW,
   parameter int MAX_BEATS = 16
) (
   input  logic            pixel_clk,
   input  logic            pixel_rst,

   input  logic            r0_cyc,
   input  logic            r0_stb,
   input  logic            r0_we,
   input  logic [AW-1:0]   r0_adr,
   input  logic [DW-1:0]   r0_dat_w,
   input  logic [DW/8-1:0] r0_sel,
   output logic            r0_ack,
   output logic [DW-1:0]   r0_dat_r,

   input  logic            r1_cyc,
   input  logic            r1_stb,
   input  logic            r1_we,
   input  logic [AW-1:0]   r1_adr,
   input  logic [DW-1:0]   r1_dat_w,
   input  logic [DW/8-1:0] r1_sel,
   output logic            r1_ack,
   output logic [DW-1:0]   r1_dat_r,

   output logic            m_cyc,
   output logic            m_stb,
   output logic            m_we,
   output logic [AW-1:0]   m_adr,
   output logic [DW-1:0]   m_dat_w,
   output logic [DW/8-1:0] m_sel,
   input  logic            m_ack,
   input  logic [DW-1:0]   m_dat_r,

   output logic [1:0]      gnt
);

   localparam int            BW        = $clog2(MAX_BEATS + 1);
   localparam logic [BW-1:0] BEATS_MAX = BW'(MAX_BEATS);

   arb_state_t    state_q, state_d;
   logic          last_q, last_d;
   logic [BW-1:0] beats_q, beats_d;
   logic [BW-1:0] beats_inc;
   logic          win;
   logic          own_cyc;
   logic          other_cyc;

   // State register
   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         beats_q <= beats_d;
      end
   end

   // Saturating increment: once the owner has used its full allowance the
   // count stays at MAX_BEATS, so any further ack while the other side is
   // asking still triggers the handover.
   always_comb begin
      beats_inc = (beats_q == BEATS_MAX) ? BEATS_MAX : beats_q + 1'b1;
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      beats_d   = beats_q;
      own_cyc   = 1'b0;
      other_cyc = 1'b0;
      win       = rr_pick(r0_cyc, r1_cyc, last_q);

      case (state_q)
         IDLE: begin
            if (r0_cyc || r1_cyc) begin
               state_d = win ? GRANT1 : GRANT0;
               last_d  = win;
               beats_d = '0;
            end
         end
         GRANT0, GRANT1: begin
            own_cyc   = (state_q == GRANT0) ? r0_cyc : r1_cyc;
            other_cyc = (state_q == GRANT0) ? r1_cyc : r0_cyc;
            if (m_ack) begin
               beats_d = beats_inc;
            end
            // A cyc drop on the same edge as the last allowed beat is simply
            // a release; both paths lead to IDLE, which gives the one-cycle
            // bubble between owners.
            if (!own_cyc || (m_ack && (beats_inc == BEATS_MAX) && other_cyc)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output mux: the owner is wired straight through, everything else is
   // held at zero so the memory side sees a clean idle bus.
   always_comb begin
      m_cyc   = 1'b0;
      m_stb   = 1'b0;
      m_we    = 1'b0;
      m_adr   = '0;
      m_dat_w = '0;
      m_sel   = '0;
      r0_ack  = 1'b0;
      r1_ack  = 1'b0;
      gnt     = 2'b00;

      case (state_q)
         GRANT0: begin
            m_cyc   = r0_cyc;
            m_stb   = r0_stb;
            m_we    = r0_we;
            m_adr   = r0_adr;
            m_dat_w = r0_dat_w;
            m_sel   = r0_sel;
            r0_ack  = m_ack;
            gnt     = 2'b01;
         end
         GRANT1: begin
            m_cyc   = r1_cyc;
            m_stb   = r1_stb;
            m_we    = r1_we;
            m_adr   = r1_adr;
            m_dat_w = r1_dat_w;
            m_sel   = r1_sel;
            r1_ack  = m_ack;
            gnt     = 2'b10;
         end
         default: ;
      endcase
   end

   // Read data is broadcast; each master only samples it on its own ack.
   assign r0_dat_r = m_dat_r;
   assign r1_dat_r = m_dat_r;

endmodule
